// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a word-write-only RAM.
// Sub-word stores are done as read-modify-write; every request gets one response pulse.
module mem_access_unit #(
  parameter int BIT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Handshake: a request transfers on a rising edge where req_valid && req_ready.
  // req_ready is high only in IDLE, and req_* must be stable while req_valid is high.
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0]  req_wdata,
  input  logic                  req_byte,
  input  logic                  req_half,
  input  logic                  req_zext,
  output logic                  resp_valid,
  output logic [BIT_WIDTH-1:0]  resp_rdata,
  output logic                  resp_misaligned,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [BIT_WIDTH-1:0]  mem_write_data,
  output logic                  mem_write_en,
  output logic                  mem_addr_byte,
  output logic                  mem_addr_half,
  output logic                  mem_zero_extend,
  input  logic [BIT_WIDTH-1:0]  mem_read_data,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    MERGE_RD = 2'd2,
    WRITE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [BIT_WIDTH-1:0]  lat_wdata;
  logic                  lat_byte;
  logic                  lat_half;
  logic                  lat_zext;
  logic [BIT_WIDTH-1:0]  merge_q;
  logic [BIT_WIDTH-1:0]  merged;

  logic req_is_byte, req_is_half, req_is_word, req_misaligned, accept;
  logic lat_is_byte, lat_is_half, lat_is_word;
  logic [ADDR_WIDTH-1:0] lat_addr_aligned;

  assign req_ready      = (state_q == IDLE);
  assign accept         = req_valid && req_ready;
  assign req_is_byte    = req_byte && !req_half;
  assign req_is_half    = !req_byte && req_half;
  assign req_is_word    = !req_is_byte && !req_is_half;
  assign req_misaligned = (req_is_half && req_addr[0]) ||
                          (req_is_word && (req_addr[1:0] != 2'b00));

  assign lat_is_byte      = lat_byte && !lat_half;
  assign lat_is_half      = !lat_byte && lat_half;
  assign lat_is_word      = !lat_is_byte && !lat_is_half;
  assign lat_addr_aligned = {lat_addr[ADDR_WIDTH-1:2], 2'b00};
  assign state_dbg        = state_q;

  // Lane replacement of the raw word read back during MERGE_RD.
  always_comb begin
    merged = mem_read_data;
    if (lat_is_byte) begin
      merged[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
    end else if (lat_is_half) begin
      merged[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    mem_read_addr   = lat_addr;
    mem_write_addr  = lat_addr;
    mem_write_data  = lat_is_word ? lat_wdata : merge_q;
    mem_write_en    = 1'b0;
    mem_addr_byte   = 1'b0;
    mem_addr_half   = 1'b0;
    mem_zero_extend = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && !req_misaligned) begin
          if (!req_write)      state_d = LOAD;
          else if (req_is_word) state_d = WRITE;
          else                  state_d = MERGE_RD;
        end
      end
      LOAD: begin
        mem_addr_byte   = lat_byte;
        mem_addr_half   = lat_half;
        mem_zero_extend = lat_zext;
        state_d         = IDLE;
      end
      MERGE_RD: begin
        mem_read_addr = lat_addr_aligned;
        state_d       = WRITE;
      end
      WRITE: begin
        mem_write_en   = 1'b1;
        mem_write_addr = lat_addr_aligned;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, merge register and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_write       <= 1'b0;
      lat_addr        <= '0;
      lat_wdata       <= '0;
      lat_byte        <= 1'b0;
      lat_half        <= 1'b0;
      lat_zext        <= 1'b0;
      merge_q         <= '0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
    end else begin
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_byte  <= req_byte;
            lat_half  <= req_half;
            lat_zext  <= req_zext;
            if (req_misaligned) begin
              resp_valid      <= 1'b1;
              resp_misaligned <= 1'b1;
            end
          end
        end
        LOAD: begin
          resp_valid <= 1'b1;
          resp_rdata <= mem_read_data;
        end
        MERGE_RD: merge_q <= merged;
        WRITE:    resp_valid <= 1'b1;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural RAM, per-scenario tasks,
// expected responses queued at drive time and popped on resp_valid.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_byte;
  logic        req_half;
  logic        req_zext;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic [31:0] mem_read_addr;
  logic [31:0] mem_write_addr;
  logic [31:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_addr_byte;
  logic        mem_addr_half;
  logic        mem_zero_extend;
  logic [31:0] mem_read_data;
  logic [1:0]  state_dbg;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        b;
    logic        h;
    logic        zext;
  } req_t;

  logic [31:0] exp_q[$];
  logic        mis_q[$];
  int          checks;
  int          errors;

  logic [31:0] ram [0:255];

  mem_access_unit #(.BIT_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_byte(req_byte),
    .req_half(req_half), .req_zext(req_zext),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
    .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_write_en(mem_write_en),
    .mem_addr_byte(mem_addr_byte), .mem_addr_half(mem_addr_half),
    .mem_zero_extend(mem_zero_extend), .mem_read_data(mem_read_data),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data_memory: whole-word writes, combinational sized reads.
  always @(posedge clk) begin
    if (mem_write_en) ram[mem_write_addr[9:2]] <= mem_write_data;
  end

  always_comb begin
    logic [31:0] w;
    logic [7:0]  bv;
    logic [15:0] hv;
    w  = ram[mem_read_addr[9:2]];
    bv = w[{mem_read_addr[1:0], 3'b000} +: 8];
    hv = w[{mem_read_addr[1], 4'b0000} +: 16];
    if (mem_addr_byte && !mem_addr_half)
      mem_read_data = mem_zero_extend ? {24'h0, bv} : {{24{bv[7]}}, bv};
    else if (!mem_addr_byte && mem_addr_half)
      mem_read_data = mem_zero_extend ? {16'h0, hv} : {{16{hv[15]}}, hv};
    else
      mem_read_data = w;
  end

  function automatic req_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input logic b, input logic h, input logic z);
    req_t r;
    r.wr = wr; r.addr = a; r.wdata = d; r.b = b; r.h = h; r.zext = z;
    return r;
  endfunction

  task automatic drive(input req_t r);
    req_write = r.wr;
    req_addr  = r.addr;
    req_wdata = r.wdata;
    req_byte  = r.b;
    req_half  = r.h;
    req_zext  = r.zext;
  endtask

  // Single request: checks response latency, data, misaligned flag and RAM write traffic.
  task automatic do_req(input string name, input req_t r, input int exp_lat,
                        input logic [31:0] exp_data, input logic exp_mis,
                        input int exp_we_at, input logic [31:0] exp_wdata);
    int n;
    int we_cnt;
    logic [31:0] ed;
    logic        em;
    exp_q.push_back(exp_data);
    mis_q.push_back(exp_mis);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: got %b want 1", name, req_ready);
    end
    drive(r);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    we_cnt = 0;
    while (n < 8) begin
      @(negedge clk);
      n++;
      if (mem_write_en === 1'b1) begin
        we_cnt++;
        checks++;
        if (n != exp_we_at || mem_write_addr !== {r.addr[31:2], 2'b00} || mem_write_data !== exp_wdata) begin
          errors++;
          $display("FAIL %s write: cycle %0d addr %h data %h, want cycle %0d addr %h data %h",
                   name, n, mem_write_addr, mem_write_data, exp_we_at, {r.addr[31:2], 2'b00}, exp_wdata);
        end
      end
      if (resp_valid === 1'b1) break;
    end
    ed = exp_q.pop_front();
    em = mis_q.pop_front();
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: no resp_valid within 8 cycles", name);
    end else begin
      if (n != exp_lat || resp_rdata !== ed || resp_misaligned !== em) begin
        errors++;
        $display("FAIL %s resp: lat %0d rdata %h mis %b, want lat %0d rdata %h mis %b",
                 name, n, resp_rdata, resp_misaligned, exp_lat, ed, em);
      end
    end
    checks++;
    if (we_cnt != ((exp_we_at > 0) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s write_count: got %0d want %0d", name, we_cnt, (exp_we_at > 0) ? 1 : 0);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || mem_write_en !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse: resp_valid %b write_en %b after response, want 0 0",
               name, resp_valid, mem_write_en);
    end
  endtask

  // Store followed by a load with req_valid held high: load must be accepted in the store's response cycle.
  task automatic do_pair(input string name, input req_t st, input int st_lat,
                         input req_t ld, input logic [31:0] ld_data);
    int n;
    logic [31:0] ed;
    logic        em;
    exp_q.push_back(32'h0);
    mis_q.push_back(1'b0);
    exp_q.push_back(ld_data);
    mis_q.push_back(1'b0);
    @(negedge clk);
    drive(st);
    req_valid = 1'b1;
    @(posedge clk);
    #1 drive(ld);
    n = 0;
    while (n < 8) begin
      @(negedge clk);
      n++;
      if (resp_valid === 1'b1) break;
    end
    ed = exp_q.pop_front();
    em = mis_q.pop_front();
    checks++;
    if (resp_valid !== 1'b1 || n != st_lat || resp_rdata !== ed || resp_misaligned !== em || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s store_resp: valid %b lat %0d rdata %h mis %b ready %b, want 1 %0d %h %b 1",
               name, resp_valid, n, resp_rdata, resp_misaligned, req_ready, st_lat, ed, em);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (n < 8) begin
      @(negedge clk);
      n++;
      if (resp_valid === 1'b1) break;
    end
    ed = exp_q.pop_front();
    em = mis_q.pop_front();
    checks++;
    if (resp_valid !== 1'b1 || n != 2 || resp_rdata !== ed || resp_misaligned !== em) begin
      errors++;
      $display("FAIL %s load_resp: valid %b lat %0d rdata %h mis %b, want 1 2 %h %b",
               name, resp_valid, n, resp_rdata, resp_misaligned, ed, em);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    drive(mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    #12;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_misaligned !== 1'b0 ||
        mem_write_en !== 1'b0 || mem_read_addr !== 32'h0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset: ready %b valid %b rdata %h mis %b we %b raddr %h state %0d, want 1 0 0 0 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_misaligned, mem_write_en, mem_read_addr, state_dbg);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_subword_store();
    do_req("sb_101", mk(1'b1, 32'h101, 32'h55, 1'b1, 1'b0, 1'b0), 3, 32'h0, 1'b0, 2, 32'hDEAD55EF);
    checks++;
    if (ram[8'h40] !== 32'hDEAD55EF) begin
      errors++;
      $display("FAIL sb_ram: got %h want DEAD55EF", ram[8'h40]);
    end
  endtask

  task automatic test_loads();
    do_req("lb_103",  mk(1'b0, 32'h103, 32'h0, 1'b1, 1'b0, 1'b0), 2, 32'hFFFFFFDE, 1'b0, 0, 32'h0);
    do_req("lbu_103", mk(1'b0, 32'h103, 32'h0, 1'b1, 1'b0, 1'b1), 2, 32'h000000DE, 1'b0, 0, 32'h0);
    do_req("lhu_102", mk(1'b0, 32'h102, 32'h0, 1'b0, 1'b1, 1'b1), 2, 32'h0000DEAD, 1'b0, 0, 32'h0);
    do_req("lh_102",  mk(1'b0, 32'h102, 32'h0, 1'b0, 1'b1, 1'b0), 2, 32'hFFFFDEAD, 1'b0, 0, 32'h0);
    do_req("lbu_100", mk(1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 1'b1), 2, 32'h000000EF, 1'b0, 0, 32'h0);
  endtask

  task automatic test_half_store();
    do_pair("sh_lw", mk(1'b1, 32'h102, 32'h1234, 1'b0, 1'b1, 1'b0), 3,
            mk(1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0), 32'h123455EF);
  endtask

  task automatic test_misaligned();
    do_req("lw_102_mis", mk(1'b0, 32'h102, 32'h0, 1'b0, 1'b0, 1'b0), 1, 32'h0, 1'b1, 0, 32'h0);
    do_req("sh_101_mis", mk(1'b1, 32'h101, 32'hBEEF, 1'b0, 1'b1, 1'b0), 1, 32'h0, 1'b1, 0, 32'h0);
    do_req("sw_103_mis", mk(1'b1, 32'h103, 32'h1, 1'b1, 1'b1, 1'b0), 1, 32'h0, 1'b1, 0, 32'h0);
    checks++;
    if (ram[8'h40] !== 32'h123455EF) begin
      errors++;
      $display("FAIL mis_ram: got %h want 123455EF", ram[8'h40]);
    end
  endtask

  task automatic test_reset_mid_merge();
    @(negedge clk);
    drive(mk(1'b1, 32'h100, 32'h77, 1'b1, 1'b0, 1'b0));
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (state_dbg !== 2'd2) begin
      errors++;
      $display("FAIL rst_merge_state: got %0d want 2", state_dbg);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_write_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_merge_now: ready %b valid %b we %b, want 1 0 0", req_ready, resp_valid, mem_write_en);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      checks++;
      if (resp_valid !== 1'b0 || mem_write_en !== 1'b0) begin
        errors++;
        $display("FAIL rst_merge_quiet: cycle %0d valid %b we %b, want 0 0", i, resp_valid, mem_write_en);
      end
    end
    checks++;
    if (ram[8'h40] !== 32'h123455EF) begin
      errors++;
      $display("FAIL rst_merge_ram: got %h want 123455EF", ram[8'h40]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] d;
    do_pair("sw_lw_104", mk(1'b1, 32'h104, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0), 2,
            mk(1'b0, 32'h104, 32'h0, 1'b0, 1'b0, 1'b0), 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) begin
      a = 32'h200 + 32'($urandom_range(0, 15)) * 4;
      d = $urandom;
      do_pair("rand_sw_lw", mk(1'b1, a, d, 1'b0, 1'b0, 1'b0), 2,
              mk(1'b0, a, 32'h0, 1'b0, 1'b0, 1'b0), d);
    end
  endtask

  task automatic test_random_sb();
    logic [31:0] a;
    logic [7:0]  v;
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      a = 32'h300 + 32'($urandom_range(0, 3));
      v = 8'($urandom);
      w = 32'hA5A5A5A5;
      ram[8'hC0] = w;
      w[{a[1:0], 3'b000} +: 8] = v;
      do_req("rand_sb", mk(1'b1, a, {24'hFFFFFF, v}, 1'b1, 1'b0, 1'b0), 3, 32'h0, 1'b0, 2, w);
      do_req("rand_lbu", mk(1'b0, a, 32'h0, 1'b1, 1'b0, 1'b1), 2, {24'h0, v}, 1'b0, 0, 32'h0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[8'h40] = 32'hDEADBEEF;
    test_reset();
    test_subword_store();
    test_loads();
    test_half_store();
    test_misaligned();
    test_reset_mid_merge();
    test_back_to_back();
    test_random_sb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the execute stage and `data_memory`, directly upstream of the RAM. It accepts one load or store request at a time over a valid/ready handshake and checks alignment. Sub-word stores become a read-modify-write, because the RAM only writes whole words. Each request returns a single-cycle response carrying load data or a misalignment flag.

## Interface
- `BIT_WIDTH`, 32: data word width; only 32 is supported.
- `ADDR_WIDTH`, 32: byte-address width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the unit can accept a request this cycle.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in BIT_WIDTH: store data, right-aligned (sb uses [7:0], sh uses [15:0]).
- `req_byte`, `req_half` in 1 each: access size. {1,0} = byte, {0,1} = half, any other combination = word.
- `req_zext` in 1: loads only; zero-extend instead of sign-extend.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out BIT_WIDTH: load result; 0 for stores and for errors.
- `resp_misaligned` out 1: qualified by `resp_valid`; the request was dropped.
- `mem_read_addr`, `mem_write_addr` out ADDR_WIDTH: to the RAM.
- `mem_write_data` out BIT_WIDTH: to the RAM.
- `mem_write_en` out 1: to the RAM.
- `mem_addr_byte`, `mem_addr_half`, `mem_zero_extend` out 1 each: size controls to the RAM.
- `mem_read_data` in BIT_WIDTH: combinational read data from the RAM.

## Operation
- States:
  - IDLE
  - LOAD
  - MERGE_RD
  - WRITE
- `req_ready` = (state == IDLE). A request is accepted when `req_valid && req_ready`; all `req_*` fields are latched into internal registers at that edge.
- Misaligned requests: half with addr[0]=1, or word with addr[1:0]≠0. State stays IDLE and there is no RAM access. The next cycle gives `resp_valid`=1, `resp_misaligned`=1, `resp_rdata`=0.
- Routing from IDLE:
  - Aligned load → LOAD.
  - Word store → WRITE.
  - Byte or half store → MERGE_RD.
- LOAD:
  - `mem_read_addr` = latched address; `mem_addr_byte`/`mem_addr_half`/`mem_zero_extend` = latched size and extension bits.
  - `mem_read_data` is registered into `resp_rdata`; `resp_valid` is set.
  - Next state IDLE.
- MERGE_RD:
  - `mem_read_addr` = latched address with [1:0] forced to 0; `mem_addr_byte`=`mem_addr_half`=`mem_zero_extend`=0, so the RAM returns the raw word.
  - Merge register = `mem_read_data` with lane replaced:
    - sb replaces bits [8·a+7 : 8·a] with wdata[7:0], where a = addr[1:0].
    - sh replaces bits [16·addr[1]+15 : 16·addr[1]] with wdata[15:0].
  - Next state WRITE.
- WRITE:
  - `mem_write_en`=1; `mem_write_addr` = latched address with [1:0]=0.
  - `mem_write_data` = merge register (word store: latched wdata).
  - Sets `resp_valid`, `resp_rdata`=0, `resp_misaligned`=0. Next state IDLE.
- Outside LOAD/MERGE_RD/WRITE: `mem_write_en`=0, size controls 0, addresses = latched address.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE; `req_ready`=1.
  - `resp_valid`=0, `resp_rdata`=0, `resp_misaligned`=0.
  - `mem_write_en`=0; all latched registers and merge register 0.
- Request accepted in cycle N; `resp_valid` is high in exactly one cycle:
  - Misaligned: N+1.
  - Load: N+2.
  - Word store: N+2; the RAM write commits at the end of N+1.
  - Sub-word store: N+3; the RAM write commits at the end of N+2.
- `req_ready` is high again in the cycle `resp_valid` is high, so the next request can be accepted in that same cycle.
- A load accepted in a store's response cycle sees the stored data, because the write has already committed.
- Reset asserted in MERGE_RD or WRITE drops the request: no RAM write occurs after reset assertion, and no response is issued.
- `mem_write_en` is decoded from registered state only; it is never combinational from `req_*`.

## Test plan
- Preload word 0x100 = 0xDEADBEEF. sb addr 0x101, wdata 0x55 accepted in cycle N → `mem_write_en` high only in N+2 with addr 0x100, data 0xDEAD55EF; `resp_valid` in N+3.
- Then lb addr 0x103 → `resp_rdata` 0xFFFFFFDE in N+2. lbu addr 0x103 → 0x000000DE. lhu addr 0x102 → 0x0000DEAD.
- sh addr 0x102, wdata 0x1234 → RAM word 0x100 becomes 0x123455EF. A lw addr 0x100 accepted in the sh response cycle returns 0x123455EF.
- lw addr 0x102 → `resp_misaligned`=1 in N+1, `resp_rdata`=0, `mem_write_en` never high. sh addr 0x101 behaves the same.
- Deassert `rst_n` during MERGE_RD of an sb → `mem_write_en` stays 0, RAM unchanged, no `resp_valid`, `req_ready`=1 immediately.
- Back-to-back: `req_valid` held high for sw 0x104 (0xCAFEF00D) then lw 0x104 → lw accepted in the sw response cycle, returns 0xCAFEF00D.
